// File: rtl/i2c_slave.sv
// I2C target with 7-bit address match: oversamples SCL/SDA on sys_clk, receives
// bytes on write, returns tx_data bytes on read, open-drain SDA, no clock stretching.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h7F
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_DATA   = 3'd3,
        RX_ACK    = 3'd4,
        TX_DATA   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_hist_r;
    logic       sda_hist_r;
    logic       scl_rise_r;
    logic       scl_fall_r;
    logic       start_r;
    logic       stop_r;
    logic       sda_lvl_r;

    state_t     state_r, state_next;
    logic [3:0] bit_cnt_r, bit_cnt_next;
    logic [7:0] shift_r, shift_next;
    logic       rw_r, rw_next;
    logic       sda_oe_r, sda_oe_next;
    logic       addr_match_r, addr_match_next;
    logic       busy_r, busy_next;
    logic [7:0] rx_data_r, rx_data_next;
    logic       rx_valid_r, rx_valid_next;
    logic       tx_req_r, tx_req_next;

    // Synchronizers, history flops and registered bus-event strobes.
    // Idle bus is high, so the flops reset to 1 to avoid false edges at reset release.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_hist_r <= 1'b1;
            sda_hist_r <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            sda_lvl_r  <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_in};
            sda_sync_r <= {sda_sync_r[0], sda_in};
            scl_hist_r <= scl_sync_r[1];
            sda_hist_r <= sda_sync_r[1];
            scl_rise_r <= scl_sync_r[1] & ~scl_hist_r;
            scl_fall_r <= ~scl_sync_r[1] & scl_hist_r;
            start_r    <= scl_sync_r[1] & scl_hist_r & ~sda_sync_r[1] & sda_hist_r;
            stop_r     <= scl_sync_r[1] & scl_hist_r & sda_sync_r[1] & ~sda_hist_r;
            sda_lvl_r  <= sda_sync_r[1];
        end
    end

    // Protocol state machine: next state and next register values.
    always_comb begin
        state_next      = state_r;
        bit_cnt_next    = bit_cnt_r;
        shift_next      = shift_r;
        rw_next         = rw_r;
        sda_oe_next     = sda_oe_r;
        addr_match_next = addr_match_r;
        busy_next       = busy_r;
        rx_data_next    = rx_data_r;
        rx_valid_next   = 1'b0;
        tx_req_next     = 1'b0;
        if (stop_r) begin
            state_next      = IDLE;
            bit_cnt_next    = 4'd0;
            sda_oe_next     = 1'b0;
            addr_match_next = 1'b0;
            busy_next       = 1'b0;
        end else if (start_r) begin
            state_next      = ADDR;
            bit_cnt_next    = 4'd0;
            sda_oe_next     = 1'b0;
            addr_match_next = 1'b0;
            busy_next       = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_next = IDLE;
                end
                ADDR: begin
                    if (scl_rise_r) begin
                        shift_next   = {shift_r[6:0], sda_lvl_r};
                        bit_cnt_next = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            if (shift_r[6:0] == SLAVE_ADDR) begin
                                rw_next = sda_lvl_r;
                            end else begin
                                sda_oe_next = 1'b0;
                                state_next  = WAIT_STOP;
                            end
                        end else begin
                            state_next = ADDR;
                        end
                    end else if (scl_fall_r && (bit_cnt_r == 4'd8)) begin
                        sda_oe_next = 1'b1;
                        state_next  = ADDR_ACK;
                    end else begin
                        state_next = ADDR;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_r) begin
                        addr_match_next = 1'b1;
                        if (rw_r) begin
                            shift_next   = tx_data;
                            tx_req_next  = 1'b1;
                            sda_oe_next  = ~tx_data[7];
                            bit_cnt_next = 4'd1;
                            state_next   = TX_DATA;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 4'd0;
                            state_next   = RX_DATA;
                        end
                    end else begin
                        state_next = ADDR_ACK;
                    end
                end
                RX_DATA: begin
                    if (scl_rise_r) begin
                        shift_next   = {shift_r[6:0], sda_lvl_r};
                        bit_cnt_next = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            rx_data_next  = {shift_r[6:0], sda_lvl_r};
                            rx_valid_next = 1'b1;
                        end else begin
                            rx_valid_next = 1'b0;
                        end
                    end else if (scl_fall_r && (bit_cnt_r == 4'd8)) begin
                        sda_oe_next = 1'b1;
                        state_next  = RX_ACK;
                    end else begin
                        state_next = RX_DATA;
                    end
                end
                RX_ACK: begin
                    if (scl_fall_r) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 4'd0;
                        state_next   = RX_DATA;
                    end else begin
                        state_next = RX_ACK;
                    end
                end
                TX_DATA: begin
                    // bit_cnt counts bits already placed on SDA; 8 means the LSB clock just ended.
                    if (scl_fall_r) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 4'd0;
                            state_next   = TX_ACK;
                        end else begin
                            sda_oe_next  = ~shift_r[6];
                            shift_next   = {shift_r[6:0], 1'b0};
                            bit_cnt_next = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_next = TX_DATA;
                    end
                end
                TX_ACK: begin
                    if (scl_rise_r) begin
                        if (sda_lvl_r) begin
                            state_next = WAIT_STOP;
                        end else begin
                            bit_cnt_next = 4'd9;
                        end
                    end else if (scl_fall_r && (bit_cnt_r == 4'd9)) begin
                        shift_next   = tx_data;
                        tx_req_next  = 1'b1;
                        sda_oe_next  = ~tx_data[7];
                        bit_cnt_next = 4'd1;
                        state_next   = TX_DATA;
                    end else begin
                        state_next = TX_ACK;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_next = 1'b0;
                end
                default: begin
                    state_next      = IDLE;
                    sda_oe_next     = 1'b0;
                    addr_match_next = 1'b0;
                    busy_next       = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 4'd0;
            shift_r      <= 8'h00;
            rw_r         <= 1'b0;
            sda_oe_r     <= 1'b0;
            addr_match_r <= 1'b0;
            busy_r       <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            tx_req_r     <= 1'b0;
        end else begin
            state_r      <= state_next;
            bit_cnt_r    <= bit_cnt_next;
            shift_r      <= shift_next;
            rw_r         <= rw_next;
            sda_oe_r     <= sda_oe_next;
            addr_match_r <= addr_match_next;
            busy_r       <= busy_next;
            rx_data_r    <= rx_data_next;
            rx_valid_r   <= rx_valid_next;
            tx_req_r     <= tx_req_next;
        end
    end

    assign sda_oe     = sda_oe_r;
    assign addr_match = addr_match_r;
    assign busy       = busy_r;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign tx_req     = tx_req_r;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged bus master, reference model of expected bytes/ACKs,
// and a scoreboard monitor popping expectations on rx_valid / tx_req.
module tb_i2c_slave;

    localparam logic [6:0] OWN_ADDR = 7'h7F;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;

    always #5 sys_clk = ~sys_clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(OWN_ADDR)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .scl_in     (scl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .busy       (busy)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_src_q[$];
    logic [7:0] buf_q[$];
    logic [7:0] model_rx = 8'h00;
    bit         oe_seen = 1'b0;
    bit         am_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops expectations when the DUT presents rx_valid or tx_req.
    initial begin : monitor
        logic prev_rx_valid;
        prev_rx_valid = 1'b0;
        tx_data = 8'hEE;
        forever begin
            @(negedge sys_clk);
            if (sda_oe) oe_seen = 1'b1;
            if (addr_match) am_seen = 1'b1;
            if (rx_valid) begin
                chk("rx_valid_width", prev_rx_valid, 1'b0);
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got rx_valid with rx_data %0h, none expected", rx_data);
                end else begin
                    chk("rx_data", rx_data, exp_rx_q.pop_front());
                end
            end
            prev_rx_valid = rx_valid;
            if (tx_req) begin
                if (tx_src_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_req_unexpected: got tx_req, none expected");
                end else begin
                    void'(tx_src_q.pop_front());
                end
            end
            tx_data = (tx_src_q.size() != 0) ? tx_src_q[0] : 8'hEE;
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        wclk(4);
        sda_m = b;
        wclk(12);
        scl = 1'b1;
        wclk(8);
        s = sda_bus;
        wclk(8);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        if (!scl) begin
            wclk(4);
            sda_m = 1'b1;
            wclk(12);
            scl = 1'b1;
        end
        wclk(8);
        sda_m = 1'b0;
        wclk(8);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        wclk(4);
        sda_m = 1'b0;
        wclk(12);
        scl = 1'b1;
        wclk(8);
        sda_m = 1'b1;
        wclk(16);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
    endtask

    // One transaction; reference model: target answers only its own address,
    // write bytes land in rx_data, read bytes come from tx_data, else bus floats high.
    task automatic xfer(input logic [7:0] abyte, input bit do_stop);
        bit         match;
        logic       ack;
        logic [7:0] d;
        int         n;
        match = (abyte[7:1] == OWN_ADDR);
        n = buf_q.size();
        if (abyte[0] && match) begin
            for (int i = 0; i < n; i++) tx_src_q.push_back(buf_q[i]);
        end
        start_cond();
        wclk(4);
        chk("busy_after_start", busy, 1'b1);
        chk("addr_match_after_start", addr_match, 1'b0);
        write_byte(abyte, ack);
        chk("addr_ack", ack, match);
        wclk(6);
        chk("addr_match", addr_match, match);
        for (int i = 0; i < n; i++) begin
            if (abyte[0]) begin
                read_byte(i == n - 1, d);
                chk("rd_byte", d, match ? buf_q[i] : 8'hFF);
            end else begin
                if (match) begin
                    exp_rx_q.push_back(buf_q[i]);
                    model_rx = buf_q[i];
                end
                write_byte(buf_q[i], ack);
                chk("data_ack", ack, match);
            end
        end
        if (do_stop) begin
            stop_cond();
            chk("busy_after_stop", busy, 1'b0);
            chk("oe_after_stop", sda_oe, 1'b0);
            chk("am_after_stop", addr_match, 1'b0);
        end
    endtask

    task automatic abort_frame(input bit use_reset);
        logic s;
        logic ack;
        start_cond();
        write_byte(8'hFE, ack);
        chk("abort_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) clock_bit(i[0], s);
        if (use_reset) begin
            rst = 1'b0;
            #1;
            chk("rst_oe", sda_oe, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rx_data", rx_data, 8'h00);
            model_rx = 8'h00;
            wclk(3);
            rst = 1'b1;
            for (int i = 0; i < 4; i++) clock_bit(1'b0, s);
            clock_bit(1'b1, s);
            chk("post_rst_no_ack", s, 1'b1);
            stop_cond();
        end else begin
            stop_cond();
            chk("stop_abort_oe", sda_oe, 1'b0);
            chk("stop_abort_busy", busy, 1'b0);
            chk("stop_abort_am", addr_match, 1'b0);
        end
        buf_q = '{8'h77};
        xfer(8'hFE, 1'b1);
    endtask

    initial begin : stimulus
        rst   = 1'b0;
        scl   = 1'b1;
        sda_m = 1'b1;
        wclk(5);
        chk("reset_sda_oe", sda_oe, 1'b0);
        chk("reset_tx_req", tx_req, 1'b0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_addr_match", addr_match, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b1;
        wclk(5);

        buf_q = '{8'h12};
        xfer(8'hFE, 1'b1);

        oe_seen = 1'b0;
        am_seen = 1'b0;
        buf_q = '{8'h55};
        xfer(8'hA0, 1'b1);
        chk("wrong_addr_no_oe", oe_seen, 1'b0);
        chk("wrong_addr_no_am", am_seen, 1'b0);

        buf_q = '{8'hA5};
        xfer(8'hFF, 1'b1);

        buf_q = '{8'h3C, 8'hC3};
        xfer(8'hFF, 1'b1);

        buf_q = '{8'h11};
        xfer(8'hFE, 1'b0);
        buf_q = '{8'h5A};
        xfer(8'hFF, 1'b1);
        chk("sr_rx_data_held", rx_data, 8'h11);

        abort_frame(1'b1);
        abort_frame(1'b0);

        for (int t = 0; t < 10; t++) begin
            logic [6:0] a7;
            logic       rw;
            int         n;
            rw = 1'($urandom_range(1, 0));
            a7 = ($urandom_range(3, 0) == 0) ? 7'($urandom_range(127, 0)) : OWN_ADDR;
            n  = $urandom_range(3, 1);
            buf_q.delete();
            for (int i = 0; i < n; i++) buf_q.push_back(8'($urandom_range(255, 0)));
            xfer({a7, rw}, 1'b1);
        end

        wclk(20);
        chk("rx_queue_drained", exp_rx_q.size(), 0);
        chk("tx_queue_drained", tx_src_q.size(), 0);
        chk("final_rx_data", rx_data, model_rx);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
